// File: rtl/tour_cmd.sv
// Replays a solved knight's tour as motion commands: each one-hot move becomes a vertical leg (opcode 2) then a horizontal leg (opcode 3).
// Latency: commands are combinational from state and move; no extra read latency. Backpressure: each leg waits on clr_cmd_rdy, then on send_resp.
// Optional macro TOUR_MOVE_CHK_EN aborts the tour on a non-one-hot move (resp=8'hEE until the next start_tour or reset).
module tour_cmd #(
    parameter int NUM_MOVES = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    input  logic        clr_cmd_rdy,
    output logic        clr_cmd_rdy_UART,
    input  logic        send_resp,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    output logic [7:0]  resp
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] VERT  = 3'd1;
    localparam logic [2:0] VHOLD = 3'd2;
    localparam logic [2:0] HORZ  = 3'd3;
    localparam logic [2:0] HHOLD = 3'd4;

    localparam logic [3:0] OP_MOVE    = 4'h2;
    localparam logic [3:0] OP_FANFARE = 4'h3;

    localparam logic [7:0] HDG_NORTH = 8'h00;
    localparam logic [7:0] HDG_WEST  = 8'h3F;
    localparam logic [7:0] HDG_SOUTH = 8'h7F;
    localparam logic [7:0] HDG_EAST  = 8'hBF;

    localparam logic [7:0] RESP_DONE  = 8'hA5;
    localparam logic [7:0] RESP_BUSY  = 8'h5A;
    localparam logic [7:0] RESP_ABORT = 8'hEE;

    localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

    logic [2:0]  state_q, state_d;
    logic [4:0]  mv_indx_q, mv_indx_d;

    logic        dx_east, dy_north;
    logic [3:0]  dx_mag, dy_mag;
    logic [15:0] vert_cmd, horz_cmd;
    logic        bad_move;
    logic        abort_show;

    // Sign/magnitude decode; anything not one-hot falls through as (0,0).
    always_comb begin
        dx_east  = 1'b0;
        dx_mag   = 4'd0;
        dy_north = 1'b0;
        dy_mag   = 4'd0;
        case (move)
            8'h01: begin dx_mag = 4'd1; dy_north = 1'b1; dy_mag = 4'd2; end
            8'h02: begin dx_east = 1'b1; dx_mag = 4'd1; dy_north = 1'b1; dy_mag = 4'd2; end
            8'h04: begin dx_mag = 4'd2; dy_north = 1'b1; dy_mag = 4'd1; end
            8'h08: begin dx_mag = 4'd2; dy_mag = 4'd1; end
            8'h10: begin dx_mag = 4'd1; dy_mag = 4'd2; end
            8'h20: begin dx_east = 1'b1; dx_mag = 4'd1; dy_mag = 4'd2; end
            8'h40: begin dx_east = 1'b1; dx_mag = 4'd2; dy_mag = 4'd1; end
            8'h80: begin dx_east = 1'b1; dx_mag = 4'd2; dy_north = 1'b1; dy_mag = 4'd1; end
            default: begin
                dx_east  = 1'b0;
                dx_mag   = 4'd0;
                dy_north = 1'b0;
                dy_mag   = 4'd0;
            end
        endcase
    end

    assign vert_cmd = {OP_MOVE,    dy_north ? HDG_NORTH : HDG_SOUTH, dy_mag};
    assign horz_cmd = {OP_FANFARE, dx_east  ? HDG_EAST  : HDG_WEST,  dx_mag};

`ifdef TOUR_MOVE_CHK_EN
    logic move_one_hot;
    logic err_q, err_d;

    assign move_one_hot = (move != 8'h00) && ((move & (move - 8'h01)) == 8'h00);
    assign bad_move     = (state_q == VERT) && !move_one_hot;
    // Abort status is visible in the offending cycle and sticks until restart.
    assign abort_show   = err_q || bad_move;

    always_comb begin
        err_d = err_q;
        if ((state_q == IDLE) && start_tour) begin
            err_d = 1'b0;
        end else if (bad_move) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    assign bad_move   = 1'b0;
    assign abort_show = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        mv_indx_d = mv_indx_q;
        case (state_q)
            IDLE: begin
                if (start_tour) begin
                    mv_indx_d = 5'd0;
                    state_d   = VERT;
                end
            end
            VERT: begin
                if (bad_move) begin
                    state_d = IDLE;
                end else if (clr_cmd_rdy) begin
                    state_d = VHOLD;
                end
            end
            VHOLD: begin
                if (send_resp) begin
                    state_d = HORZ;
                end
            end
            HORZ: begin
                if (clr_cmd_rdy) begin
                    state_d = HHOLD;
                end
            end
            HHOLD: begin
                if (send_resp) begin
                    if (mv_indx_q == LAST_IDX) begin
                        state_d = IDLE;
                    end else begin
                        mv_indx_d = mv_indx_q + 5'd1;
                        state_d   = VERT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mv_indx_q <= 5'd0;
        end else begin
            state_q   <= state_d;
            mv_indx_q <= mv_indx_d;
        end
    end

    assign mv_indx = mv_indx_q;

    // UART traffic only reaches the command processor while no tour is running.
    always_comb begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        case (state_q)
            IDLE: begin
                cmd              = cmd_UART;
                cmd_rdy          = cmd_rdy_UART;
                clr_cmd_rdy_UART = clr_cmd_rdy;
            end
            VERT: begin
                cmd              = vert_cmd;
                cmd_rdy          = !bad_move;
                clr_cmd_rdy_UART = 1'b0;
            end
            VHOLD: begin
                cmd              = vert_cmd;
                cmd_rdy          = 1'b0;
                clr_cmd_rdy_UART = 1'b0;
            end
            HORZ: begin
                cmd              = horz_cmd;
                cmd_rdy          = 1'b1;
                clr_cmd_rdy_UART = 1'b0;
            end
            HHOLD: begin
                cmd              = horz_cmd;
                cmd_rdy          = 1'b0;
                clr_cmd_rdy_UART = 1'b0;
            end
            default: begin
                cmd              = cmd_UART;
                cmd_rdy          = 1'b0;
                clr_cmd_rdy_UART = 1'b0;
            end
        endcase
    end

    always_comb begin
        if (abort_show) begin
            resp = RESP_ABORT;
        end else if ((state_q == IDLE) || ((state_q == HHOLD) && (mv_indx_q == LAST_IDX))) begin
            resp = RESP_DONE;
        end else begin
            resp = RESP_BUSY;
        end
    end

endmodule

// File: doc/tour_cmd.md
Name: tour_cmd

Overview:
- Sits directly downstream of the knight's-tour solver.
- Once the solver pulses done, it walks the 24 stored moves by driving the solver's move index. Each one-hot move is translated into two motion commands for the command processor: a vertical leg, then a horizontal leg.
- When no tour is active, it passes UART-originated commands straight through to the command processor.
- It also generates the response byte returned to the host.

Parameters:
- NUM_MOVES, 24, number of moves in a complete 5x5 tour; last index = NUM_MOVES-1.

Ports:
- clk  in  1  system clock (50MHz)
- rst_n  in  1  asynchronous active-low reset
- start_tour  in  1  single-cycle pulse (solver done); begins tour playback
- move  in  8  one-hot move from solver at index mv_indx
- mv_indx  out  5  index of move being read from solver
- cmd_UART  in  16  command from UART wrapper
- cmd_rdy_UART  in  1  UART command valid
- clr_cmd_rdy  in  1  command processor has consumed cmd
- clr_cmd_rdy_UART  out  1  forwarded consume strobe to UART wrapper
- send_resp  in  1  command processor finished current command
- cmd  out  16  command to command processor
- cmd_rdy  out  1  cmd valid
- resp  out  8  response byte to host

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rst_n). All flops clear on reset: state=IDLE, mv_indx=0.
- Command format: [15:12] opcode, [11:4] heading, [3:0] squares.
  - Vertical leg opcode = 4'h2 (move).
  - Horizontal leg opcode = 4'h3 (move with fanfare).
  - Headings: north 8'h00, west 8'h3F, south 8'h7F, east 8'hBF.
- Move decode (+y north, +x east), giving (dx,dy):
  - bit0 (-1,+2), bit1 (+1,+2), bit2 (-2,+1), bit3 (-2,-1)
  - bit4 (-1,-2), bit5 (+1,-2), bit6 (+2,-1), bit7 (+2,+1)
  - Vertical cmd: heading north if dy>0 else south; squares=|dy|.
  - Horizontal cmd: heading east if dx>0 else west; squares=|dx|.
- States: IDLE, VERT, VHOLD, HORZ, HHOLD.
- IDLE:
  - cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy.
  - On start_tour: mv_indx<=0, go to VERT.
- VERT: cmd=vertical cmd of move, cmd_rdy=1. On clr_cmd_rdy go to VHOLD (cmd_rdy drops the next cycle).
- VHOLD: cmd_rdy=0, cmd held. On send_resp go to HORZ.
- HORZ: as VERT with the horizontal cmd. On clr_cmd_rdy go to HHOLD.
- HHOLD: on send_resp:
  - if mv_indx==NUM_MOVES-1, go to IDLE with mv_indx held;
  - else mv_indx<=mv_indx+1, go to VERT.
- Outside IDLE:
  - clr_cmd_rdy_UART=0.
  - cmd_rdy_UART and cmd_UART are ignored; no UART command is forwarded mid-tour.
- move is sampled combinationally; the solver's move output is stable for a given mv_indx. No extra read latency.
- resp = 8'hA5 when state==IDLE, or when in HHOLD at the last index. Otherwise resp = 8'h5A.
- Boundaries:
  - start_tour outside IDLE: ignored.
  - clr_cmd_rdy and send_resp in the same cycle in VERT/HORZ: clr wins; send_resp is ignored.
  - send_resp in VERT/HORZ without a prior clr: ignored.
  - rst_n low mid-tour: immediately IDLE, mv_indx=0, cmd_rdy follows cmd_rdy_UART.

Optional Feature:
- Macro TOUR_MOVE_CHK_EN.
- Defined: in VERT, a move that is not exactly one-hot (zero or multiple bits set) aborts the tour. Go to IDLE, do not assert cmd_rdy for that move, and drive resp=8'hEE until the next start_tour or reset.
- Undefined: no check. A non-one-hot move decodes as (0,0) and both legs are issued with squares=0.

Test Plan:
- Idle passthrough: cmd_UART=16'h2123, cmd_rdy_UART=1, pulse clr_cmd_rdy -> cmd=16'h2123, cmd_rdy=1, clr_cmd_rdy_UART pulses, resp=8'hA5.
- Single move bit1 at index 0: start_tour -> cmd=16'h2002 with cmd_rdy. After clr then send_resp -> cmd=16'h3BF1. After clr then send_resp -> mv_indx=1.
- Full tour: 24 scripted moves with handshakes -> exactly 48 commands in decode order. mv_indx runs 0..23, resp=8'h5A mid-tour, 8'hA5 after the final send_resp, state back at IDLE.
- Move bit3 (-2,-1) -> vertical cmd 16'h27F1, horizontal cmd 16'h33F2.
- start_tour during HHOLD, and cmd_rdy_UART asserted mid-tour -> ignored. Same-cycle clr_cmd_rdy+send_resp in VERT -> only the VHOLD transition occurs.
- Reset asserted in HORZ at mv_indx=7 -> next edge state IDLE, mv_indx=0. With TOUR_MOVE_CHK_EN, move=8'h03 -> no cmd_rdy, resp=8'hEE.
